// File: rtl/riscv_alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: opcodes, funct3 codes and ALU operation encodings.
// Optional ALU_ILLEGAL_FLAG_EN adds the Illegal/IllegalReg flag outputs in the interface and top.
package riscv_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_XXX    = 4'd15
  } alu_op_t;

  // Codes 11..14 are reserved and behave exactly like XXX.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op > 4'd10);
  endfunction

endpackage

// File: rtl/riscv_alu_unit_if.sv
// Operand/result bundle between the execute stage control and the ALU.
// ALU_ILLEGAL_FLAG_EN adds the Illegal and IllegalReg flag signals.
interface riscv_alu_unit_if;

  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic        Stall;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] OutReg;
`ifdef ALU_ILLEGAL_FLAG_EN
  logic        Illegal;
  logic        IllegalReg;
`endif

  modport master (
    output opcode, funct, add_rshift_type, A, B, Stall,
`ifdef ALU_ILLEGAL_FLAG_EN
    input  Illegal, IllegalReg,
`endif
    input  ALUop, Out, OutReg
  );

  modport slave (
    input  opcode, funct, add_rshift_type, A, B, Stall,
`ifdef ALU_ILLEGAL_FLAG_EN
    output Illegal, IllegalReg,
`endif
    output ALUop, Out, OutReg
  );

endinterface

// File: rtl/alu_op_decoder.sv
// Maps opcode/funct3/instruction bit 30 onto the 4-bit ALU operation code.
module alu_op_decoder
  import riscv_alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct,
  input  logic       add_rshift_type,
  output alu_op_t    alu_op
);

  alu_op_t arith_op;

  // funct3 decode shared by OP and OP-IMM; only OP may turn 000 into SUB.
  always_comb begin
    arith_op = ALU_XXX;
    case (funct)
      F3_ADD_SUB: arith_op = (opcode == OPC_ARI_RTYPE && add_rshift_type) ? ALU_SUB : ALU_ADD;
      F3_SLL:     arith_op = ALU_SLL;
      F3_SLT:     arith_op = ALU_SLT;
      F3_SLTU:    arith_op = ALU_SLTU;
      F3_XOR:     arith_op = ALU_XOR;
      F3_SRL_SRA: arith_op = add_rshift_type ? ALU_SRA : ALU_SRL;
      F3_OR:      arith_op = ALU_OR;
      F3_AND:     arith_op = ALU_AND;
      default:    arith_op = ALU_XXX;
    endcase
  end

  always_comb begin
    alu_op = ALU_XXX;
    case (opcode)
      OPC_LUI:       alu_op = ALU_COPY_B;
      OPC_AUIPC,
      OPC_JAL,
      OPC_JALR,
      OPC_BRANCH,
      OPC_LOAD,
      OPC_STORE:     alu_op = ALU_ADD;
      OPC_ARI_ITYPE,
      OPC_ARI_RTYPE: alu_op = arith_op;
      default:       alu_op = ALU_XXX;
    endcase
  end

endmodule

// File: rtl/riscv_alu_unit.sv
// RV32I execute-stage ALU: combinational result plus a stallable registered copy.
// Define ALU_ILLEGAL_FLAG_EN to also drive Illegal/IllegalReg for undecodable instructions.
module riscv_alu_unit
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = riscv_alu_pkg::XLEN
) (
  input  logic             Clock,
  input  logic             Reset,
  riscv_alu_unit_if.slave  bus
);

  alu_op_t          alu_op;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [4:0]       shamt;
  logic [XLEN-1:0]  out_next;
  logic [XLEN-1:0]  out_reg;

  assign op_a  = bus.A;
  assign op_b  = bus.B;
  assign shamt = bus.B[4:0];

  alu_op_decoder u_decoder (
    .opcode          (bus.opcode),
    .funct           (bus.funct),
    .add_rshift_type (bus.add_rshift_type),
    .alu_op          (alu_op)
  );

  always_comb begin
    out_next = '0;
    case (alu_op)
      ALU_ADD:    out_next = op_a + op_b;
      ALU_SUB:    out_next = op_a - op_b;
      ALU_SLL:    out_next = op_a << shamt;
      ALU_SLT:    out_next = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:   out_next = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:    out_next = op_a ^ op_b;
      ALU_SRL:    out_next = op_a >> shamt;
      ALU_SRA:    out_next = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:     out_next = op_a | op_b;
      ALU_AND:    out_next = op_a & op_b;
      ALU_COPY_B: out_next = op_b;
      default:    out_next = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_reg <= '0;
    end else if (!bus.Stall) begin
      out_reg <= out_next;
    end
  end

  assign bus.ALUop  = alu_op;
  assign bus.Out    = out_next;
  assign bus.OutReg = out_reg;

`ifdef ALU_ILLEGAL_FLAG_EN
  logic illegal_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      illegal_reg <= 1'b0;
    end else if (!bus.Stall) begin
      illegal_reg <= is_illegal_op(alu_op);
    end
  end

  assign bus.Illegal    = is_illegal_op(alu_op);
  assign bus.IllegalReg = illegal_reg;
`endif

endmodule

// File: tb/tb_riscv_alu_unit.sv
// Self-checking bench for riscv_alu_unit: directed corner cases plus a randomized sweep against a reference model.
module tb_riscv_alu_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  riscv_alu_unit_if bus ();

  riscv_alu_unit dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: operation name by instruction class, then plain arithmetic on that name.
  function automatic int ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
    int op_tbl[8];
    op_tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (opc == 7'b0110111) return 10;
    if (opc == 7'b0010111 || opc == 7'b1101111 || opc == 7'b1100111 ||
        opc == 7'b1100011 || opc == 7'b0000011 || opc == 7'b0100011) return 0;
    if (opc == 7'b0010011 || opc == 7'b0110011) begin
      if (f3 == 3'd0) return (opc == 7'b0110011 && b30) ? 1 : 0;
      if (f3 == 3'd5) return b30 ? 7 : 6;
      return op_tbl[f3];
    end
    return 15;
  endfunction

  function automatic logic [31:0] ref_out(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh  = b % 32;
    ext = {{32{a[31]}}, a};
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a * (32'd1 << sh);
      3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a / (33'd1 << sh);
      7:  begin ext = ext >> sh; return ext[31:0]; end
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b30,
                       input logic [31:0] a, input logic [31:0] b);
    bus.opcode = opc;
    bus.funct = f3;
    bus.add_rshift_type = b30;
    bus.A = a;
    bus.B = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Stall = 1'b0;
    drive(7'b0110011, 3'd0, 1'b0, 32'h11, 32'h22);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.OutReg !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outreg got %h expected %h", bus.OutReg, 32'h0);
    end
    vectors++;
    if (bus.Out !== 32'h33) begin
      miscompares++;
      $display("FAIL reset_out_comb got %h expected %h", bus.Out, 32'h33);
    end
`ifdef ALU_ILLEGAL_FLAG_EN
    vectors++;
    if (bus.IllegalReg !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_illegalreg got %b expected 0", bus.IllegalReg);
    end
`endif
    $display("reset: OutReg=%h Out=%h", bus.OutReg, bus.Out);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vectors: opcode, funct3, bit30, A, B, expected ALUop, expected Out.
  task automatic test_directed();
    logic [6:0]  t_opc[14];
    logic [2:0]  t_f3[14];
    logic        t_b30[14];
    logic [31:0] t_a[14];
    logic [31:0] t_b[14];
    logic [3:0]  t_op[14];
    logic [31:0] t_out[14];
    t_opc = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h33, 7'h33, 7'h13,
              7'h37, 7'h23, 7'h7F, 7'h33, 7'h33, 7'h13};
    t_f3  = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd2, 3'd3, 3'd0,
              3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    t_b30 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t_a   = '{32'h5, 32'h5, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h3,
              32'hDEADBEEF, 32'h100, 32'h1234, 32'h7FFFFFFF, 32'h0, 32'hCAFEF00D};
    t_b   = '{32'h7, 32'h7, 32'h1F, 32'h1F, 32'hFFFFFFE4, 32'h1, 32'h1, 32'h2,
              32'h12345000, 32'hFFFFFFFC, 32'h5678, 32'h1, 32'h1, 32'hFFFFFFE0};
    t_op  = '{4'd1, 4'd0, 4'd7, 4'd6, 4'd7, 4'd3, 4'd4, 4'd0,
              4'd10, 4'd0, 4'd15, 4'd0, 4'd1, 4'd2};
    t_out = '{32'hFFFFFFFE, 32'hC, 32'hFFFFFFFF, 32'h1, 32'hF8000000, 32'h1, 32'h0, 32'h5,
              32'h12345000, 32'hFC, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hCAFEF00D};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(t_opc[i], t_f3[i], t_b30[i], t_a[i], t_b[i]);
      #1;
      vectors++;
      if (bus.ALUop !== t_op[i]) begin
        miscompares++;
        $display("FAIL directed_aluop[%0d] got %0d expected %0d", i, bus.ALUop, t_op[i]);
      end
      vectors++;
      if (bus.Out !== t_out[i]) begin
        miscompares++;
        $display("FAIL directed_out[%0d] got %h expected %h", i, bus.Out, t_out[i]);
      end
`ifdef ALU_ILLEGAL_FLAG_EN
      vectors++;
      if (bus.Illegal !== (t_op[i] == 4'd15)) begin
        miscompares++;
        $display("FAIL directed_illegal[%0d] got %b expected %b", i, bus.Illegal, t_op[i] == 4'd15);
      end
`endif
      $display("directed %0d: opc=%b f3=%0d b30=%b A=%h B=%h -> op=%0d Out=%h",
               i, t_opc[i], t_f3[i], t_b30[i], t_a[i], t_b[i], bus.ALUop, bus.Out);
    end
  endtask

  task automatic test_stall_reset();
    @(negedge clk);
    bus.Stall = 1'b0;
    drive(7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2);
    @(posedge clk); #1;
    vectors++;
    if (bus.OutReg !== 32'd3) begin
      miscompares++;
      $display("FAIL seq_add_outreg got %h expected %h", bus.OutReg, 32'd3);
    end
    @(negedge clk);
    bus.Stall = 1'b1;
    drive(7'b0110011, 3'd4, 1'b0, 32'hF0, 32'hFF);
    #1;
    vectors++;
    if (bus.Out !== 32'h0F) begin
      miscompares++;
      $display("FAIL seq_stall_out got %h expected %h", bus.Out, 32'h0F);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.OutReg !== 32'd3) begin
      miscompares++;
      $display("FAIL seq_stall_hold got %h expected %h", bus.OutReg, 32'd3);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.OutReg !== 32'd0) begin
      miscompares++;
      $display("FAIL seq_reset_over_stall got %h expected %h", bus.OutReg, 32'd0);
    end
    vectors++;
    if (bus.Out !== 32'h0F) begin
      miscompares++;
      $display("FAIL seq_reset_out_follows got %h expected %h", bus.Out, 32'h0F);
    end
    $display("sequential: OutReg=%h Out=%h after reset with stall", bus.OutReg, bus.Out);
    @(negedge clk);
    rst = 1'b0;
    bus.Stall = 1'b0;
  endtask

  task automatic test_random_sweep();
    logic [6:0]  opc_pool[12];
    logic [31:0] special[6];
    logic [31:0] exp_reg;
    logic [31:0] exp_out;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b30;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    int          op;
`ifdef ALU_ILLEGAL_FLAG_EN
    logic        exp_ill_reg;
    exp_ill_reg = 1'b0;
`endif
    opc_pool = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h13, 7'h33, 7'h00};
    special  = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h1F};
    exp_reg = 32'h0;
    for (int i = 0; i < 96; i++) begin
      opc = opc_pool[$urandom_range(0, 11)];
      if (opc == 7'h00) opc = 7'($urandom);
      f3  = 3'($urandom);
      b30 = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      stall = ($urandom_range(0, 4) == 0);
      op = ref_op(opc, f3, b30);
      exp_out = ref_out(op, a, b);
      @(negedge clk);
      bus.Stall = stall;
      drive(opc, f3, b30, a, b);
      #1;
      vectors++;
      if (bus.ALUop !== 4'(op)) begin
        miscompares++;
        $display("FAIL rand_aluop[%0d] got %0d expected %0d", i, bus.ALUop, op);
      end
      vectors++;
      if (bus.Out !== exp_out) begin
        miscompares++;
        $display("FAIL rand_out[%0d] got %h expected %h", i, bus.Out, exp_out);
      end
      if (!stall) exp_reg = exp_out;
`ifdef ALU_ILLEGAL_FLAG_EN
      if (!stall) exp_ill_reg = (op == 15);
`endif
      @(posedge clk); #1;
      vectors++;
      if (bus.OutReg !== exp_reg) begin
        miscompares++;
        $display("FAIL rand_outreg[%0d] got %h expected %h", i, bus.OutReg, exp_reg);
      end
`ifdef ALU_ILLEGAL_FLAG_EN
      vectors++;
      if (bus.IllegalReg !== exp_ill_reg) begin
        miscompares++;
        $display("FAIL rand_illegalreg[%0d] got %b expected %b", i, bus.IllegalReg, exp_ill_reg);
      end
`endif
      $display("rand %0d: opc=%b f3=%0d b30=%b stall=%b A=%h B=%h -> op=%0d Out=%h OutReg=%h",
               i, opc, f3, b30, stall, a, b, bus.ALUop, bus.Out, bus.OutReg);
    end
  endtask

  initial begin
    bus.Stall = 1'b0;
    drive(7'h0, 3'h0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_directed();
    test_stall_reset();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_alu_unit.md
Name: riscv_alu_unit

Overview:
- RV32I execute-stage arithmetic block for the RISC-V pipeline.
- Decodes opcode/funct3/instruction bit 30 into a 4-bit ALU operation, then computes a 32-bit result combinationally.
- Also provides a registered copy of the result for the following pipeline stage.
- One clock; reset is synchronous and active-high.

Parameters:
- XLEN, 32, datapath width; only 32 is supported. Shift amount is B[4:0].

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0].
- funct  in  3  instruction[14:12] (funct3).
- add_rshift_type  in  1  instruction[30]; selects SUB vs ADD and SRA vs SRL.
- A  in  32  operand A (rs1 or PC, muxed outside this block).
- B  in  32  operand B (rs2 or immediate, muxed outside this block).
- Stall  in  1  when high, OutReg holds its value.
- ALUop  out  4  decoded operation, combinational.
- Out  out  32  result, combinational (zero latency).
- OutReg  out  32  Out registered on the rising edge of Clock.

Behaviour:
- ALUop encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, COPY_B=10, XXX=15. Codes 11-14 are unused and treated as XXX.
- Decode by opcode:
  - LUI 0110111 -> COPY_B.
  - AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011 -> ADD. funct and add_rshift_type are ignored.
  - OP-IMM 0010011, by funct3: 000 ADD (bit 30 ignored), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA if add_rshift_type else SRL, 110 OR, 111 AND.
  - OP 0110011: same as OP-IMM, except 000 -> SUB if add_rshift_type else ADD.
  - Any other opcode -> XXX.
- Arithmetic, all modulo 2^32 with no overflow flag:
  - ADD: A+B. SUB: A-B.
  - SLL: A<<B[4:0]. SRL: logical right shift. SRA: arithmetic right shift, sign bit A[31] replicated. B[31:5] is ignored for all shifts.
  - SLT: 1 if signed A < signed B, else 0; zero-extended to 32 bits.
  - SLTU: unsigned compare, same output format.
  - XOR, OR, AND: bitwise.
  - COPY_B: Out = B.
  - XXX: Out = 0.
- Out and ALUop are purely combinational and must settle within the same timestep as their inputs. No dependence on Clock or Reset.
- OutReg, on each rising edge of Clock, in priority order:
  1. Reset=1 -> 0.
  2. Stall=1 -> hold.
  3. Otherwise -> Out.
- Reset value of OutReg is 0. Reset takes priority over Stall. Reset mid-stream clears OutReg on the next edge; Out continues to follow inputs.
- Boundary cases:
  - 0x7FFFFFFF+1 = 0x80000000.
  - 0-1 = 0xFFFFFFFF.
  - SRA of 0x80000000 by 31 = 0xFFFFFFFF.
  - Shift by 0 returns A unchanged.
  - SLT(0x80000000, 0) = 1; SLTU of the same operands = 0.

Optional Feature:
- Macro ALU_ILLEGAL_FLAG_EN.
- Defined: adds output port Illegal (1 bit, combinational), high when ALUop == XXX. Also adds IllegalReg, registered with the same Reset/Stall rules as OutReg; reset value 0.
- Undefined: neither port exists. Out remains 0 for XXX operations.

Decomposition:
- Package riscv_alu_pkg: opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_ARI_ITYPE, OPC_ARI_RTYPE), funct3 constants, and the ALUop encodings.
- One sub-module, alu_op_decoder: opcode/funct/add_rshift_type -> ALUop.
- The datapath and OutReg register live in the top module.

Test Plan:
- OP 0110011, funct 000, bit30=1, A=0x00000005, B=0x00000007 -> ALUop=SUB, Out=0xFFFFFFFE. Bit30=0 -> Out=0x0000000C.
- OP-IMM 0010011, funct 101, bit30=1, A=0x80000000, B=0x0000001F -> Out=0xFFFFFFFF. Bit30=0 -> Out=0x00000001. B=0xFFFFFFE4 gives shift 4: SRA -> 0xF8000000.
- OP 0110011, A=0x80000000, B=0x00000001: funct 010 -> Out=1; funct 011 -> Out=0. OP-IMM funct 000 with bit30=1, A=3, B=2 -> Out=5 (bit 30 ignored).
- LUI 0110111, A=0xDEADBEEF, B=0x12345000 -> Out=0x12345000. STORE 0100011, A=0x100, B=0xFFFFFFFC -> Out=0x000000FC. Opcode 1111111 -> ALUop=15, Out=0 (Illegal=1 when ALU_ILLEGAL_FLAG_EN is defined).
- Sequential: hold Reset high for 2 edges -> OutReg=0. Release, apply ADD 1+2 -> OutReg=3 after one edge. Stall=1 while applying XOR 0xF0^0xFF -> OutReg stays 3 and Out=0x0F. Assert Reset together with Stall -> OutReg=0.
- Randomized sweep: 85+ vectors across all opcode/funct combinations, compared against a golden model; check Out with #1 settling and OutReg one cycle later.
